// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx: 8N1 serial receiver, companion to the team's UART transmitter.
//
// The asynchronous line goes through a two-flop synchroniser. All decisions
// use the second flop. The start bit is confirmed at its midpoint, and every
// following bit is then sampled one bit period later, near its centre.
// A good byte is presented on rx_b together with a one-cycle rx_dv_out strobe.
// A low stop bit gives a one-cycle rx_frame_err_out strobe instead.
//
// Optional feature (macro UART_RX_PARITY_EN):
//   defined   -> 8E1 frames. A parity bit is checked between the data bits
//                and the stop bit. On a mismatch, rx_parity_err_out pulses
//                and rx_dv_out is suppressed.
//   undefined -> 8N1 frames. rx_parity_err_out is tied to 0.
//
// Parameter:
//   clk_per_bit  clock cycles per UART bit (clk freq / baud), legal 4..255
//
// Ports:
//   clk                input   system clock, rising edge
//   rst                input   asynchronous active-high reset
//   rx_serial_in       input   raw serial line (idles high, asynchronous)
//   rx_dv_out          output  one-cycle pulse: rx_b holds a new byte
//   rx_b[7:0]          output  last good byte (LSB first on the line)
//   rx_active_out      output  high while a frame is being received
//   rx_frame_err_out   output  one-cycle pulse: stop bit sampled low
//   rx_parity_err_out  output  one-cycle pulse: parity mismatch
//
// Output strobes: each strobe is registered and lasts exactly one clk.
// There is no backpressure. The consumer must take rx_b in the cycle that
// rx_dv_out is high, or at any time before the next strobe, because rx_b
// holds its value between frames.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int clk_per_bit = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial_in,
  output logic       rx_dv_out,
  output logic [7:0] rx_b,
  output logic       rx_active_out,
  output logic       rx_frame_err_out,
  output logic       rx_parity_err_out
);

  localparam logic [7:0] CPB_M1 = 8'(clk_per_bit - 1);
  localparam logic [7:0] HALF   = 8'((clk_per_bit - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_CLEANUP = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [2:0] index_q, index_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_b_q, rx_b_d;
  logic       dv_q, dv_d;
  logic       ferr_q, ferr_d;
  logic       active_q, active_d;
  logic       sync1_q, rx_sync_q;
`ifdef UART_RX_PARITY_EN
  logic       perr_q, perr_d;
  logic       parity_bad_q, parity_bad_d;
`endif

  // The synchroniser flops reset to the idle (high) line level, so that
  // leaving reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      sync1_q   <= rx_serial_in;
      rx_sync_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= 8'd0;
      index_q      <= 3'd0;
      shift_q      <= 8'd0;
      rx_b_q       <= 8'd0;
      dv_q         <= 1'b0;
      ferr_q       <= 1'b0;
      active_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q       <= 1'b0;
      parity_bad_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      index_q      <= index_d;
      shift_q      <= shift_d;
      rx_b_q       <= rx_b_d;
      dv_q         <= dv_d;
      ferr_q       <= ferr_d;
      active_q     <= active_d;
`ifdef UART_RX_PARITY_EN
      perr_q       <= perr_d;
      parity_bad_q <= parity_bad_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    index_d  = index_q;
    shift_d  = shift_q;
    rx_b_d   = rx_b_q;
    active_d = active_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d       = 1'b0;
    parity_bad_d = parity_bad_q;
`endif

    case (state_q)
      S_IDLE: begin
        count_d  = 8'd0;
        index_d  = 3'd0;
        active_d = 1'b0;
        if (!rx_sync_q) begin
          state_d  = S_START;
          active_d = 1'b1;
        end
      end

      // Confirm the start bit at its midpoint. A line that is already high
      // again by then was a glitch, and the frame is dropped silently.
      S_START: begin
        if (count_q < HALF) begin
          count_d = count_q + 8'd1;
        end else if (!rx_sync_q) begin
          count_d = 8'd0;
          state_d = S_DATA;
        end else begin
          count_d  = 8'd0;
          active_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      S_DATA: begin
        if (count_q < CPB_M1) begin
          count_d = count_q + 8'd1;
        end else begin
          count_d          = 8'd0;
          shift_d[index_q] = rx_sync_q;
          if (index_q < 3'd7) begin
            index_d = index_q + 3'd1;
          end else begin
            index_d = 3'd0;
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      // Even parity: the line bit must equal the XOR of the data bits.
      S_PARITY: begin
        if (count_q < CPB_M1) begin
          count_d = count_q + 8'd1;
        end else begin
          count_d      = 8'd0;
          parity_bad_d = rx_sync_q ^ (^shift_q);
          state_d      = S_STOP;
        end
      end
`endif

      // A low stop bit takes priority over a parity mismatch, so that only
      // one strobe ever fires per frame.
      S_STOP: begin
        if (count_q < CPB_M1) begin
          count_d = count_q + 8'd1;
        end else begin
          count_d  = 8'd0;
          active_d = 1'b0;
          state_d  = S_CLEANUP;
          if (!rx_sync_q) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (parity_bad_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            dv_d   = 1'b1;
            rx_b_d = shift_q;
          end
        end
      end

      // Wait for the line to return high, so that a break or a stuck-low line
      // after a frame is not taken as a new start bit.
      S_CLEANUP: begin
        if (rx_sync_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_dv_out        = dv_q;
  assign rx_b             = rx_b_q;
  assign rx_active_out    = active_q;
  assign rx_frame_err_out = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err_out = perr_q;
`else
  assign rx_parity_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx: self-checking bench for uart_rx.
// A table of frames is applied in a loop. Hand-written sequences then cover
// the glitch, the stuck-low line after a frame error, and reset mid-frame.
// Expected bytes are queued when a frame is driven. Bytes seen on rx_dv_out
// are collected by the monitor and compared against that queue.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB = 87;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       rx_serial_in;
  logic       rx_dv_out;
  logic [7:0] rx_b;
  logic       rx_active_out;
  logic       rx_frame_err_out;
  logic       rx_parity_err_out;

  always #5 clk = ~clk;

  uart_rx #(.clk_per_bit(CPB)) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_serial_in      (rx_serial_in),
    .rx_dv_out         (rx_dv_out),
    .rx_b              (rx_b),
    .rx_active_out     (rx_active_out),
    .rx_frame_err_out  (rx_frame_err_out),
    .rx_parity_err_out (rx_parity_err_out)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] model_b = 8'h00;

  int  dv_cnt = 0, ferr_cnt = 0, perr_cnt = 0, overlap_cnt = 0, long_cnt = 0;
  logic prev_dv = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;
  longint last_dv_t = 0;
  longint last_start_t = 0;

  // Monitor: samples on the falling edge and only records what it sees.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_dv_out) begin
        dv_cnt++;
        got_q.push_back(rx_b);
        last_dv_t = $time;
      end
      if (rx_frame_err_out)  ferr_cnt++;
      if (rx_parity_err_out) perr_cnt++;
      if (int'(rx_dv_out) + int'(rx_frame_err_out) + int'(rx_parity_err_out) > 1)
        overlap_cnt++;
      if ((rx_dv_out && prev_dv) || (rx_frame_err_out && prev_ferr) ||
          (rx_parity_err_out && prev_perr))
        long_cnt++;
      prev_dv   = rx_dv_out;
      prev_ferr = rx_frame_err_out;
      prev_perr = rx_parity_err_out;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drain_sb();
    check("sb_count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check("sb_byte", got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    rx_serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_serial_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par_flip);
    logic good;
    good = stop;
`ifdef UART_RX_PARITY_EN
    good = stop && !par_flip;
`endif
    if (good) begin
      exp_q.push_back(data);
      model_b = data;
    end
    last_start_t = $time;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(data[i]);
      if (i == 0) check("active_mid_frame", rx_active_out, 1);
    end
`ifdef UART_RX_PARITY_EN
    send_bit((^data) ^ par_flip);
`endif
    send_bit(stop);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par_flip;
    int         gap;
    logic [7:0] exp_b;
    int         exp_dv;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  vec_t vecs[$];
  int   exp_dv_tot = 0, exp_ferr_tot = 0, exp_perr_tot = 0;
  longint lat;
  int   act_hi;

  initial begin
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 200, 8'hA5, 1, 0, 0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 0,   8'h00, 1, 0, 0});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 0,   8'hFF, 1, 0, 0});
    vecs.push_back('{8'h3C, 1'b1, 1'b0, 200, 8'h3C, 1, 0, 0});
    vecs.push_back('{8'h80, 1'b1, 1'b0, 150, 8'h80, 1, 0, 0});
    vecs.push_back('{8'hC3, 1'b0, 1'b0, 150, 8'h80, 0, 1, 0});
    vecs.push_back('{8'h01, 1'b1, 1'b0, 150, 8'h01, 1, 0, 0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b0, 150, 8'h07, 1, 0, 0});
    vecs.push_back('{8'h07, 1'b1, 1'b1, 150, 8'h07, 0, 0, 1});
    vecs.push_back('{8'h5A, 1'b0, 1'b1, 150, 8'h07, 0, 1, 0});
`endif

    // reset
    rst = 1'b1;
    rx_serial_in = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_dv", rx_dv_out, 0);
    check("reset_b", rx_b, 0);
    check("reset_active", rx_active_out, 0);
    check("reset_ferr", rx_frame_err_out, 0);
    check("reset_perr", rx_parity_err_out, 0);
    idle_cycles(20);

    // table-driven frames
    for (int i = 0; i < vecs.size(); i++) begin
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].par_flip);
      exp_dv_tot   += vecs[i].exp_dv;
      exp_ferr_tot += vecs[i].exp_ferr;
      exp_perr_tot += vecs[i].exp_perr;
      if (vecs[i].gap > 0) begin
        idle_cycles(vecs[i].gap);
        check("tbl_dv_cnt", dv_cnt, exp_dv_tot);
        check("tbl_ferr_cnt", ferr_cnt, exp_ferr_tot);
        check("tbl_perr_cnt", perr_cnt, exp_perr_tot);
        check("tbl_rx_b", rx_b, vecs[i].exp_b);
        check("tbl_active_idle", rx_active_out, 0);
        drain_sb();
        if (i == 0) begin
          lat = (last_dv_t - last_start_t) / 10;
          check("latency_in_range", (lat >= 829 && lat <= 831), 1);
        end
      end
    end

    // 20-clk glitch on the idle line
    rx_serial_in = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_active", rx_active_out, 1);
    repeat (10) @(negedge clk);
    idle_cycles(46);
    check("glitch_active_cleared", rx_active_out, 0);
    idle_cycles(100);
    check("glitch_dv_cnt", dv_cnt, exp_dv_tot);
    check("glitch_ferr_cnt", ferr_cnt, exp_ferr_tot);
    check("glitch_rx_b", rx_b, model_b);

    // frame error followed by a stuck-low line
    send_frame(8'h55, 1'b0, 1'b0);
    exp_ferr_tot++;
    act_hi = 0;
    rx_serial_in = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (rx_active_out) act_hi++;
    end
    check("stuck_low_no_restart", act_hi, 0);
    check("stuck_low_ferr_cnt", ferr_cnt, exp_ferr_tot);
    check("stuck_low_dv_cnt", dv_cnt, exp_dv_tot);
    check("stuck_low_rx_b", rx_b, model_b);
    idle_cycles(50);
    send_frame(8'h81, 1'b1, 1'b0);
    exp_dv_tot++;
    idle_cycles(150);
    check("after_break_rx_b", rx_b, 8'h81);
    check("after_break_dv_cnt", dv_cnt, exp_dv_tot);
    drain_sb();

    // reset during data bit 4; the rest of the frame has no falling edge
    begin
      logic [7:0] d;
      d = 8'hF3;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      rx_serial_in = d[4];
      repeat (CPB / 2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_dv", rx_dv_out, 0);
      check("rst_mid_b", rx_b, 0);
      check("rst_mid_active", rx_active_out, 0);
      check("rst_mid_ferr", rx_frame_err_out, 0);
      check("rst_mid_perr", rx_parity_err_out, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (CPB - CPB / 2 - 3) @(negedge clk);
      for (int i = 5; i < 8; i++) send_bit(d[i]);
      send_bit(1'b1);
      model_b = 8'h00;
    end
    idle_cycles(200);
    check("rst_abort_dv_cnt", dv_cnt, exp_dv_tot);
    check("rst_abort_ferr_cnt", ferr_cnt, exp_ferr_tot);
    check("rst_abort_rx_b", rx_b, model_b);
    send_frame(8'h12, 1'b1, 1'b0);
    exp_dv_tot++;
    idle_cycles(150);
    check("post_rst_rx_b", rx_b, 8'h12);
    check("post_rst_dv_cnt", dv_cnt, exp_dv_tot);
    drain_sb();

    // strobe hygiene over the whole run
    check("strobe_overlap", overlap_cnt, 0);
    check("strobe_width", long_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
